// File: rtl/acc_core.sv
// acc_core: single-clock FETCH/DECODE/EXEC accumulator CPU between a sync program ROM and a sync data RAM.
// Define ACC_CORE_CARRY_EN to get the carry flag plus ADC (D) / SBC (E); otherwise carry reads 0 and D/E are NOPs.
module acc_core #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int MAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  output logic [AW-1:0]  imem_addr,
  input  logic [MAW+3:0] imem_rdata,
  output logic [MAW-1:0] dmem_addr,
  output logic           dmem_re,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  acc,
  output logic           zero,
  output logic           carry,
  output logic           halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hC;
`ifdef ACC_CORE_CARRY_EN
  localparam logic [3:0] OP_ADC = 4'hD;
  localparam logic [3:0] OP_SBC = 4'hE;
`endif

  state_e         state_q, state_next;
  logic [MAW+3:0] instr_q;
  logic [AW-1:0]  pc_q, pc_next;
  logic [DW-1:0]  acc_q, acc_next;
  logic           zero_q, acc_wr, go;
  logic [3:0]     dec_op, op;
  logic [MAW-1:0] dec_operand, operand;
  logic [DW-1:0]  m, add_res, sub_res;

  assign dec_op      = imem_rdata[MAW+3:MAW];
  assign dec_operand = imem_rdata[MAW-1:0];
  assign op          = instr_q[MAW+3:MAW];
  assign operand     = instr_q[MAW-1:0];
  assign m           = dmem_rdata;
  // Strobes are qualified combinationally so a frozen or resetting core never issues one.
  assign go          = ena && !rst;

  function automatic logic reads_mem(input logic [3:0] o);
    case (o)
      OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_JMP, OP_BZ: reads_mem = 1'b1;
`ifdef ACC_CORE_CARRY_EN
      OP_ADC, OP_SBC: reads_mem = 1'b1;
`endif
      default: reads_mem = 1'b0;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state_q;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    case (state_q)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_EXEC;
        dmem_re    = go && reads_mem(dec_op);
      end
      S_EXEC: begin
        state_next = (op == OP_HLT) ? S_HALT : S_FETCH;
        dmem_we    = go && (op == OP_STA);
      end
      default:  state_next = S_HALT;
    endcase
  end

`ifdef ACC_CORE_CARRY_EN
  logic          carry_q, carry_next, add_cout, sub_nob;
  logic [DW:0]   add_full, sub_full;
  assign add_full = {1'b0, acc_q} + {1'b0, m} + (DW+1)'(op == OP_ADC && carry_q);
  assign sub_full = {1'b0, acc_q} - {1'b0, m} - (DW+1)'(op == OP_SBC && !carry_q);
  assign add_res  = add_full[DW-1:0];
  assign add_cout = add_full[DW];
  assign sub_res  = sub_full[DW-1:0];
  assign sub_nob  = !sub_full[DW];
  assign carry    = carry_q;
`else
  assign add_res  = acc_q + m;
  assign sub_res  = acc_q - m;
  assign carry    = 1'b0;
`endif

  always_comb begin
    pc_next  = pc_q + AW'(1);
    acc_next = acc_q;
    acc_wr   = 1'b0;
`ifdef ACC_CORE_CARRY_EN
    carry_next = carry_q;
`endif
    case (op)
      OP_LDA: begin acc_next = m;              acc_wr = 1'b1; end
      OP_LDI: begin acc_next = DW'(operand);   acc_wr = 1'b1; end
      OP_ADD: begin
        acc_next = add_res;
        acc_wr   = 1'b1;
`ifdef ACC_CORE_CARRY_EN
        carry_next = add_cout;
`endif
      end
      OP_SUB: begin
        acc_next = sub_res;
        acc_wr   = 1'b1;
`ifdef ACC_CORE_CARRY_EN
        carry_next = sub_nob;
`endif
      end
      OP_AND: begin acc_next = acc_q & m;      acc_wr = 1'b1; end
      OP_OR:  begin acc_next = acc_q | m;      acc_wr = 1'b1; end
      OP_XOR: begin acc_next = acc_q ^ m;      acc_wr = 1'b1; end
      OP_SHL: begin acc_next = {acc_q[DW-MAW-1:0], {MAW{1'b0}}}; acc_wr = 1'b1; end
      OP_JMP: pc_next = m[AW-1:0];
      OP_BZ:  if (zero_q) pc_next = m[AW-1:0];
      OP_HLT: pc_next = pc_q;
`ifdef ACC_CORE_CARRY_EN
      OP_ADC: begin acc_next = add_res; acc_wr = 1'b1; carry_next = add_cout; end
      OP_SBC: begin acc_next = sub_res; acc_wr = 1'b1; carry_next = sub_nob;  end
`endif
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
`ifdef ACC_CORE_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else if (ena) begin
      state_q <= state_next;
      if (state_q == S_DECODE) instr_q <= imem_rdata;
      if (state_q == S_EXEC) begin
        pc_q <= pc_next;
        if (acc_wr) begin
          acc_q  <= acc_next;
          zero_q <= (acc_next == '0);
        end
`ifdef ACC_CORE_CARRY_EN
        carry_q <= carry_next;
`endif
      end
    end
  end

  // Operand is still on the ROM bus during DECODE; afterwards it comes from the latched instruction.
  assign dmem_addr  = (state_q == S_DECODE) ? dec_operand : operand;
  assign dmem_wdata = acc_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign acc        = acc_q;
  assign zero       = zero_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: instruction-level reference model compared every cycle, plus hand-computed directed checks.
module tb_acc_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] imem_addr, imem_rdata;
  logic [3:0] dmem_addr;
  logic       dmem_re, dmem_we;
  logic [7:0] dmem_wdata, dmem_rdata, pc, acc;
  logic       zero, carry, halted;

  acc_core #(.DW(8), .AW(8), .MAW(4)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .pc(pc), .acc(acc), .zero(zero), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

`ifdef ACC_CORE_CARRY_EN
  localparam bit HAS_C = 1'b1;
`else
  localparam bit HAS_C = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memories: ROM and RAM are synchronous; RAM reloads its initial image while rst is high.
  logic [7:0] rom      [256];
  logic [7:0] ram_init [16];
  logic [7:0] ram      [16];
  int         we_count;
  logic [3:0] we_addr;
  logic [7:0] we_data;

  always @(posedge clk) begin
    imem_rdata <= rom[imem_addr];
    if (rst) begin
      ram      <= ram_init;
      we_count <= 0;
    end else begin
      if (dmem_re) dmem_rdata <= ram[dmem_addr];
      if (dmem_we) begin
        ram[dmem_addr] <= dmem_wdata;
        we_count       <= we_count + 1;
        we_addr        <= dmem_addr;
        we_data        <= dmem_wdata;
      end
    end
  end

  // Reference model: whole instruction executes on its third enabled cycle.
  logic [7:0] mram [16];
  int m_pc, m_acc, m_zero, m_carry, m_halt, phase;

  function automatic bit reads(input int op);
    return (op == 1) || (op >= 4 && op <= 8) || op == 10 || op == 11 ||
           (HAS_C && (op == 13 || op == 14));
  endfunction

  task automatic model_exec();
    int op, opnd, m, r, nxt;
    op   = int'(rom[m_pc][7:4]);
    opnd = int'(rom[m_pc][3:0]);
    m    = int'(mram[opnd]);
    nxt  = (m_pc + 1) % 256;
    r    = -1;
    case (op)
      1:  r = m;
      2:  r = opnd;
      3:  mram[opnd] = 8'(m_acc);
      4:  begin r = m_acc + m; if (HAS_C) m_carry = int'(r > 255); end
      5:  begin if (HAS_C) m_carry = int'(m_acc >= m); r = m_acc - m + 256; end
      6:  r = m_acc & m;
      7:  r = m_acc | m;
      8:  r = m_acc ^ m;
      9:  r = m_acc * 16;
      10: nxt = m;
      11: if (m_zero != 0) nxt = m;
      12: begin nxt = m_pc; m_halt = 1; end
      13: if (HAS_C) begin r = m_acc + m + m_carry; m_carry = int'(r > 255); end
      14: if (HAS_C) begin r = m_acc - m - (1 - m_carry); m_carry = int'(r >= 0); r = r + 256; end
      default: ;
    endcase
    if (r >= 0) begin
      m_acc  = r % 256;
      m_zero = int'(m_acc == 0);
    end
    m_pc = nxt;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_acc = 0; m_zero = 1; m_carry = 0; m_halt = 0; phase = 0;
      mram = ram_init;
    end else if (ena && m_halt == 0) begin
      if (phase == 2) begin
        model_exec();
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  bit cmp_on = 1'b0;

  always @(negedge clk) begin : compare
    bit live, e_re, e_we;
    int cur_op;
    if (cmp_on) begin
      live   = !rst && ena && (m_halt == 0);
      cur_op = int'(rom[m_pc][7:4]);
      e_re   = live && phase == 1 && reads(cur_op);
      e_we   = live && phase == 2 && cur_op == 3;
      check("model imem_addr", 32'(imem_addr), 32'(m_pc));
      check("model pc", 32'(pc), 32'(m_pc));
      check("model acc", 32'(acc), 32'(m_acc));
      check("model zero", 32'(zero), 32'(m_zero));
      check("model carry", 32'(carry), 32'(m_carry));
      check("model halted", 32'(halted), 32'(m_halt));
      check("model dmem_re", 32'(dmem_re), 32'(e_re));
      check("model dmem_we", 32'(dmem_we), 32'(e_we));
      if (e_re || e_we) check("model dmem_addr", 32'(dmem_addr), 32'(rom[m_pc][3:0]));
      if (e_we) check("model dmem_wdata", 32'(dmem_wdata), 32'(m_acc));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 16; i++) ram_init[i] = 8'h00;
  endtask

  // Caller loads rom/ram_init after this returns with rst high, then calls release_rst.
  task automatic enter_rst();
    rst = 1'b1;
    ena = 1'b1;
    clear_mem();
  endtask

  task automatic release_rst();
    wait_cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    clear_mem();
    wait_cycles(1);
    cmp_on = 1'b1;

    // 1: reset state
    wait_cycles(1);
    check("rst pc", 32'(pc), 32'h0);
    check("rst acc", 32'(acc), 32'h0);
    check("rst zero", 32'(zero), 32'h1);
    check("rst carry", 32'(carry), 32'h0);
    check("rst halted", 32'(halted), 32'h0);
    check("rst imem_addr", 32'(imem_addr), 32'h0);

    // 2: LDI 5; STA 3; LDA 3; HLT
    enter_rst();
    rom[0] = 8'h25; rom[1] = 8'h33; rom[2] = 8'h13; rom[3] = 8'hC0;
    release_rst();
    wait_cycles(11);
    check("prog2 halted@11", 32'(halted), 32'h0);
    wait_cycles(1);
    check("prog2 halted@12", 32'(halted), 32'h1);
    check("prog2 acc", 32'(acc), 32'h05);
    check("prog2 pc", 32'(pc), 32'h03);
    check("prog2 we_count", 32'(we_count), 32'h1);
    check("prog2 we_addr", 32'(we_addr), 32'h3);
    check("prog2 we_data", 32'(we_data), 32'h05);
    wait_cycles(4);
    check("prog2 pc hold", 32'(pc), 32'h03);
    check("prog2 ram3", 32'(ram[3]), 32'h05);

    // 3: ADD overflow, then a sweep of ALU ops
    enter_rst();
    ram_init[1] = 8'hFF; ram_init[2] = 8'h01; ram_init[3] = 8'h05;
    ram_init[4] = 8'hF0; ram_init[5] = 8'h0A; ram_init[6] = 8'hFF;
    rom[0] = 8'h11; rom[1] = 8'h42; rom[2] = 8'hD2; rom[3] = 8'h52;
    rom[4] = 8'hE3; rom[5] = 8'h64; rom[6] = 8'h75; rom[7] = 8'h86;
    rom[8] = 8'h90; rom[9] = 8'h27; rom[10] = 8'h3E; rom[11] = 8'h1E;
    rom[12] = 8'hC0;
    release_rst();
    wait_cycles(6);
    check("add ovf acc", 32'(acc), 32'h00);
    check("add ovf zero", 32'(zero), 32'h1);
    check("add ovf carry", 32'(carry), 32'(HAS_C));
    wait_cycles(33);
    check("alu halted", 32'(halted), 32'h1);
    check("alu acc", 32'(acc), 32'h07);
    check("alu ram14", 32'(ram[14]), 32'h07);

    // 4: BZ taken / not taken, JMP, pc wrap
    enter_rst();
    ram_init[1] = 8'h40; ram_init[2] = 8'hFE;
    rom[0] = 8'h20; rom[1] = 8'hB1;
    rom[8'h40] = 8'h21; rom[8'h41] = 8'hB1; rom[8'h42] = 8'hA2;
    rom[8'hFE] = 8'h00; rom[8'hFF] = 8'hF0;
    release_rst();
    wait_cycles(6);
    check("bz taken pc", 32'(pc), 32'h40);
    wait_cycles(6);
    check("bz not taken pc", 32'(pc), 32'h42);
    wait_cycles(3);
    check("jmp pc", 32'(pc), 32'hFE);
    wait_cycles(3);
    check("nop pc", 32'(pc), 32'hFF);
    wait_cycles(3);
    check("wrap pc", 32'(pc), 32'h00);

    // 5: ena low for 5 cycles in DECODE of LDA 3
    enter_rst();
    ram_init[3] = 8'h5A;
    rom[0] = 8'h13; rom[1] = 8'hC0;
    release_rst();
    wait_cycles(1);
    check("ena re before", 32'(dmem_re), 32'h1);
    check("ena re addr", 32'(dmem_addr), 32'h3);
    ena = 1'b0;
    #1;
    check("ena re frozen", 32'(dmem_re), 32'h0);
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      check("ena frozen pc", 32'(pc), 32'h0);
      check("ena frozen re", 32'(dmem_re), 32'h0);
    end
    ena = 1'b1;
    #1;
    check("ena re reissued", 32'(dmem_re), 32'h1);
    wait_cycles(2);
    check("ena acc", 32'(acc), 32'h5A);
    check("ena zero", 32'(zero), 32'h0);
    wait_cycles(3);
    check("ena halted", 32'(halted), 32'h1);

    // 6: rst during DECODE and during EXEC of STA drops the write
    enter_rst();
    ram_init[4] = 8'h77;
    rom[0] = 8'h29; rom[1] = 8'h34; rom[2] = 8'hC0;
    release_rst();
    wait_cycles(4);
    rst = 1'b1;
    wait_cycles(1);
    check("rst dec pc", 32'(pc), 32'h0);
    check("rst dec acc", 32'(acc), 32'h0);
    check("rst dec imem_addr", 32'(imem_addr), 32'h0);
    check("rst dec we", 32'(dmem_we), 32'h0);
    rst = 1'b0;
    wait_cycles(5);
    check("sta exec we", 32'(dmem_we), 32'h1);
    check("sta exec wdata", 32'(dmem_wdata), 32'h09);
    rst = 1'b1;
    #1;
    check("rst exec we", 32'(dmem_we), 32'h0);
    wait_cycles(1);
    check("rst exec ram4", 32'(ram[4]), 32'h77);
    rst = 1'b0;
    wait_cycles(9);
    check("sta rerun halted", 32'(halted), 32'h1);
    check("sta rerun ram4", 32'(ram[4]), 32'h09);
    check("sta rerun we_count", 32'(we_count), 32'h1);

    wait_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
